// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO round-robin write arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    // Index width, never below one bit so a two-producer arbiter still has an id.
    function automatic int idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Burst counter must be able to hold BURST_LEN itself.
    function automatic int burst_cnt_w(input int burst_len);
        return (burst_len <= 1) ? 1 : $clog2(burst_len + 1);
    endfunction

endpackage

// File: rtl/fifo_rr_wr_arbiter_rr_pick.sv
// Round-robin picker: first set mask bit scanning start, start+1, ... modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; found=0 when mask is empty.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDW = idw(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDW-1:0]     start,
    output logic               found,
    output logic [IDW-1:0]     idx
);

    logic [IDW-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDW'((int'(start) + i) % NUM_REQ);
            if (!found && mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_wr_arbiter.sv
// Shares one FIFO write port among NUM_REQ producers with round-robin bursts of up to BURST_LEN.
// Latency: zero cycles; the granted word is written in the cycle it is granted.
// Backpressure: fifo_full drops every ready and freezes all arbitration state.
module fifo_rr_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    localparam int IDW = idw(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [IDW-1:0]                gnt_id
);

    localparam int             CW   = burst_cnt_w(BURST_LEN);
    localparam logic [CW-1:0]  BL   = CW'(BURST_LEN);
    localparam logic [IDW-1:0] LAST = IDW'(NUM_REQ - 1);

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] last_q, last_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IDW-1:0] base, start;
    logic           pick_found;
    logic [IDW-1:0] pick_idx;
    logic           grant;
    logic [IDW-1:0] gid;
    logic           grant_ok;

    // In HOLD the scan starts after the owner so the owner itself is considered last.
    assign base  = (state_q == IDLE) ? last_q : owner_q;
    assign start = (base == LAST) ? '0 : base + 1'b1;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .mask  (req_valid),
        .start (start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        grant   = 1'b0;
        gid     = '0;
        if (!fifo_full) begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant   = 1'b1;
                        gid     = pick_idx;
                        owner_d = pick_idx;
                        last_d  = pick_idx;
                        cnt_d   = CW'(1);
                        state_d = (BURST_LEN == 1) ? IDLE : HOLD;
                    end
                end
                HOLD: begin
                    if (req_valid[owner_q] && (cnt_q < BL)) begin
                        grant = 1'b1;
                        gid   = owner_q;
                        cnt_d = cnt_q + 1'b1;
                    end else if (pick_found) begin
                        grant   = 1'b1;
                        gid     = pick_idx;
                        owner_d = pick_idx;
                        last_d  = pick_idx;
                        cnt_d   = CW'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= LAST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are masked by reset directly so they drop without waiting for a clock.
    assign grant_ok  = rst & grant;
    assign fifo_w_en = grant_ok;
    assign gnt_id    = grant_ok ? gid : '0;

    always_comb begin
        req_ready    = '0;
        fifo_data_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_ok && (gid == IDW'(i))) begin
                req_ready[i] = 1'b1;
                fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
// Self-checking bench for fifo_rr_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, BURST_LEN=4).
// Vector table plus a hand-written mid-burst reset sequence, checked through a scoreboard queue.
module tb_fifo_rr_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BL = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_w_en;
    logic [DW-1:0]   fifo_data_in;
    logic [1:0]      gnt_id;

    fifo_rr_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_w_en    (fifo_w_en),
        .fifo_data_in (fifo_data_in),
        .gnt_id       (gnt_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] vld;
        logic       full;
        logic       wen;
        logic [1:0] gid;
        string      name;
    } vec_t;

    typedef struct {
        logic          wen;
        logic [1:0]    gid;
        logic [DW-1:0] data;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Unique word per (cycle, producer) so lost or duplicated writes show up as data errors.
    function automatic logic [DW-1:0] mkdata(input int c, input int i);
        logic [31:0] v;
        v = (c << 2) | i;
        return v[DW-1:0];
    endfunction

    function automatic void add(input int rep, input logic r, input logic [3:0] v,
                                input logic f, input logic w, input logic [1:0] g,
                                input string nm);
        vec_t e;
        e.rst_n = r; e.vld = v; e.full = f; e.wen = w; e.gid = g; e.name = nm;
        for (int k = 0; k < rep; k++) vecs.push_back(e);
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] v, input logic f,
                         input logic ew, input logic [1:0] eg);
        exp_t e;
        rst       = r;
        req_valid = v;
        fifo_full = f;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = mkdata(cyc, i);
        e.wen  = ew;
        e.gid  = ew ? eg : 2'd0;
        e.data = ew ? mkdata(cyc, int'(eg)) : '0;
        sb.push_back(e);
    endtask

    task automatic check_out(input string nm);
        exp_t       e;
        logic [3:0] er;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty, got w_en=%b", nm, fifo_w_en);
        end else begin
            e  = sb.pop_front();
            er = e.wen ? (4'b0001 << e.gid) : 4'b0000;
            cmp({nm, ".w_en"},  32'(fifo_w_en),    32'(e.wen));
            cmp({nm, ".gnt_id"}, 32'(gnt_id),      32'(e.gid));
            cmp({nm, ".ready"}, 32'(req_ready),    32'(er));
            cmp({nm, ".data"},  32'(fifo_data_in), 32'(e.data));
        end
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;

        // Reset holds outputs low even with every producer requesting.
        add(2, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, "reset");
        // Full rotation with everyone valid: four bursts of four.
        for (int k = 0; k < N; k++) add(BL, 1'b1, 4'b1111, 1'b0, 1'b1, 2'(k), "rotate_all");
        // Single producer streams across burst boundaries without bubbles.
        add(1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, "reset_t3");
        add(1, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, "idle_none");
        add(10, 1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, "solo_2");
        // Full stalls mid-burst; burst count resumes afterwards.
        add(1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, "reset_t4");
        add(2, 1'b1, 4'b0110, 1'b0, 1'b1, 2'd1, "pre_full");
        add(3, 1'b1, 4'b0110, 1'b1, 1'b0, 2'd0, "full");
        add(2, 1'b1, 4'b0110, 1'b0, 1'b1, 2'd1, "post_full");
        add(2, 1'b1, 4'b0110, 1'b0, 1'b1, 2'd2, "after_burst");
        // Owner drops valid: immediate hand-over, then wrap back to 0.
        add(1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, "reset_t5");
        add(1, 1'b1, 4'b1001, 1'b0, 1'b1, 2'd0, "own0");
        add(BL, 1'b1, 4'b1000, 1'b0, 1'b1, 2'd3, "handover_3");
        add(1, 1'b1, 4'b1001, 1'b0, 1'b1, 2'd0, "wrap_0");

        for (int r = 0; r < vecs.size(); r++) begin
            @(negedge clk);
            cyc++;
            drive(vecs[r].rst_n, vecs[r].vld, vecs[r].full, vecs[r].wen, vecs[r].gid);
            #2;
            check_out(vecs[r].name);
        end

        // Mid-burst reset: owner 2 has burst_cnt=3 when rst falls.
        @(negedge clk);
        cyc++;
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
        #2 check_out("reset_t6");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cyc++;
            drive(1'b1, 4'b0100, 1'b0, 1'b1, 2'd2);
            #2 check_out("burst_2");
        end
        @(negedge clk);
        cyc++;
        drive(1'b1, 4'b0100, 1'b0, 1'b1, 2'd2);
        #1 check_out("burst_2_4th");
        rst = 1'b0;
        sb.push_back('{1'b0, 2'd0, '0});
        #1 check_out("async_drop");
        @(negedge clk);
        cyc++;
        drive(1'b1, 4'b1111, 1'b0, 1'b1, 2'd0);
        #2 check_out("post_reset_prio");

        cmp("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
